bus_arbiter_rr: RTL

N-client bus arbiter between the existing client blocks (rq/ack/wr_ni/dataW/dataR protocol) and one shared synchronous memory port. It accepts one request at a time and selects the winner by round-robin or fixed priority. It drives a single memory access, returns read data, and acknowledges the winner. Requests outside the configured address window are rejected with an error flag instead of reaching memory.

---
 rtl/bus_arbiter_rr.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - N-client round-robin / fixed-priority arbiter onto one synchronous memory port
module bus_arbiter_rr #(
    parameter int NUM_CLIENTS          = 4,
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ARB_MODE             = 0,
    parameter int MEM_LATENCY          = 1,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            rq,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CLIENTS-1:0]            wr_ni,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
    output logic [NUM_CLIENTS-1:0]            ack,
    output logic                              err,
    output logic [DATA_WIDTH-1:0]             dataR,
    output logic                              mem_en,
    output logic                              mem_wr_ni,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_dataW,
    input  logic [DATA_WIDTH-1:0]             mem_dataR
);

    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_grant;
    logic                    r_in_window;
    logic [CW-1:0]           r_cnt;
    logic [NUM_CLIENTS-1:0]  r_ack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_dataR;
    logic                    r_mem_en;
    logic                    r_mem_wr_ni;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_dataW;

    logic [IW-1:0]           w_win;
    logic [ADDR_WIDTH-1:0]   w_addr_sel;
    logic [DATA_WIDTH-1:0]   w_data_sel;
    logic                    w_wr_sel;
    logic                    w_in_window;

    // Round-robin searches upward from the client after the last winner, wrapping.
    function automatic logic [IW-1:0] f_pick(input logic [NUM_CLIENTS-1:0] req,
                                             input logic [IW-1:0]          ptr);
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (req[IW'(i)]) begin
                    win = IW'(i);
                end
            end
        end else begin
            for (int off = 1; off <= NUM_CLIENTS; off++) begin
                idx = (int'(ptr) + off) % NUM_CLIENTS;
                if (!found && req[IW'(idx)]) begin
                    found = 1'b1;
                    win   = IW'(idx);
                end
            end
        end
        return win;
    endfunction

    function automatic logic f_in_window(input logic [ADDR_WIDTH-1:0] a);
        int x;
        x = int'({{(32-ADDR_WIDTH){1'b0}}, a});
        return (x >= ADDR_SPACE_BEGINNING) && (x <= ADDR_SPACE_END);
    endfunction

    assign w_win       = f_pick(rq, r_ptr);
    assign w_addr_sel  = address[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_sel  = dataW[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_wr_sel    = wr_ni[w_win];
    assign w_in_window = f_in_window(w_addr_sel);

    // Request fields go straight into the mem_* registers at grant, so they are
    // already stable on the port during the ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= IW'(NUM_CLIENTS - 1);
            r_grant     <= '0;
            r_in_window <= 1'b0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_dataR     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr_ni <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dataW <= '0;
        end else begin
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_mem_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|rq) begin
                        r_grant     <= w_win;
                        r_ptr       <= w_win;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wr_ni <= w_wr_sel;
                        r_mem_dataW <= w_data_sel;
                        r_in_window <= w_in_window;
                        r_mem_en    <= w_in_window;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_cnt   <= CW'(MEM_LATENCY - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_in_window && !r_mem_wr_ni) begin
                            r_dataR <= mem_dataR;
                        end
                        r_ack   <= NUM_CLIENTS'(1) << r_grant;
                        r_err   <= !r_in_window;
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign dataR     = r_dataR;
    assign mem_en    = r_mem_en;
    assign mem_wr_ni = r_mem_wr_ni;
    assign mem_addr  = r_mem_addr;
    assign mem_dataW = r_mem_dataW;

endmodule
